// File: rtl/mc_datapath.sv
// mc_datapath: multicycle MIPS-subset datapath (add, sub, and, or, slt, lw,
// sw, beq, addi, j) with an internal control FSM, register file and a single
// shared instruction/data memory port using a req/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   mem_req    memory access request (FETCH, MEMRD, MEMWR)
//   mem_we     1 = write, 0 = read; valid while mem_req=1
//   mem_addr   byte address (pc in FETCH, ALUOut otherwise)
//   mem_wdata  store data (B register)
//   mem_rdata  read data, valid when mem_ready=1
//   mem_ready  access completes on the edge where mem_req & mem_ready
//   pc         current program counter
//   state      FSM state encoding, for debug
//   retire     one-cycle pulse in the final state of each instruction
//   trap       invalid-instruction flag
//
// Build option: define MC_INVALID_TRAP_EN to park the FSM in TRAP on an
// invalid opcode/funct; otherwise invalid instructions retire as NOPs.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [3:0]  state,
  output logic        retire,
  output logic        trap
);

  localparam int unsigned RW = $clog2(NUM_REGS);

  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEX   = 4'd6,  S_RTWB   = 4'd7,  S_ADDIEX = 4'd8;
  localparam logic [3:0] S_ADDIWB = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000, OP_J   = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100, FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

`ifdef MC_INVALID_TRAP_EN
  localparam logic NOP_ON_INVALID = 1'b0;
`else
  localparam logic NOP_ON_INVALID = 1'b1;
`endif
  localparam logic [3:0] S_ON_INVALID = NOP_ON_INVALID ? S_FETCH : S_TRAP;

  logic [3:0]    r_state, w_next_state;
  logic [31:0]   r_pc, r_ir, r_a, r_b, r_alu_out, r_mdr;
  logic          r_active;
  logic [31:0]   r_regs [NUM_REGS];

  logic [5:0]    w_opcode, w_funct;
  logic [RW-1:0] w_rs, w_rt, w_rd, w_rf_waddr;
  logic [31:0]   w_imm_sext, w_rs_val, w_rt_val, w_alu_result, w_rf_wdata;
  logic          w_op_valid, w_funct_valid, w_mem_fire, w_rf_we;

  assign w_opcode   = r_ir[31:26];
  assign w_funct    = r_ir[5:0];
  assign w_rs       = r_ir[21 +: RW];
  assign w_rt       = r_ir[16 +: RW];
  assign w_rd       = r_ir[11 +: RW];
  assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};

  assign w_rs_val = (w_rs == '0) ? '0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == '0) ? '0 : r_regs[w_rt];

  // r_active is low for the first cycle after any reset edge, so a
  // transaction in flight at reset is dropped and mem_req reads 0 then.
  assign mem_req    = r_active && (r_state == S_FETCH || r_state == S_MEMRD ||
                                   r_state == S_MEMWR);
  assign mem_we     = r_active && (r_state == S_MEMWR);
  assign mem_addr   = (r_state == S_FETCH) ? r_pc : r_alu_out;
  assign mem_wdata  = r_b;
  assign w_mem_fire = mem_req && mem_ready;

  assign pc    = r_pc;
  assign state = r_state;
  assign trap  = !NOP_ON_INVALID && (r_state == S_TRAP);

  always_comb begin
    w_op_valid = 1'b0;
    case (w_opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_op_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_alu_result  = '0;
    w_funct_valid = 1'b1;
    case (w_funct)
      FN_ADD:  w_alu_result = r_a + r_b;
      FN_SUB:  w_alu_result = r_a - r_b;
      FN_AND:  w_alu_result = r_a & r_b;
      FN_OR:   w_alu_result = r_a | r_b;
      FN_SLT:  w_alu_result = {31'b0, ($signed(r_a) < $signed(r_b))};
      default: w_funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (w_mem_fire) w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OP_RTYPE:     w_next_state = S_RTEX;
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_ON_INVALID;
        endcase
      end
      S_MEMADR: w_next_state = (w_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (w_mem_fire) w_next_state = S_MEMWB;
      S_MEMWR:  if (w_mem_fire) w_next_state = S_FETCH;
      S_RTEX:   w_next_state = w_funct_valid ? S_RTWB : S_ON_INVALID;
      S_ADDIEX: w_next_state = S_ADDIWB;
      S_MEMWB, S_RTWB, S_ADDIWB, S_BRANCH, S_JUMP: w_next_state = S_FETCH;
      S_TRAP:   w_next_state = S_TRAP;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // In NOP mode an invalid instruction retires in the state that detects it.
  always_comb begin
    retire = 1'b0;
    case (r_state)
      S_MEMWB, S_RTWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEMWR:  retire = w_mem_fire;
      S_DECODE: retire = NOP_ON_INVALID && !w_op_valid;
      S_RTEX:   retire = NOP_ON_INVALID && !w_funct_valid;
      default:  retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_active  <= 1'b0;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
    end else begin
      r_state  <= w_next_state;
      r_active <= 1'b1;
      case (r_state)
        S_FETCH: begin
          if (w_mem_fire) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + 32'd4;
          end
        end
        S_DECODE: begin
          r_a       <= w_rs_val;
          r_b       <= w_rt_val;
          r_alu_out <= r_pc + {w_imm_sext[29:0], 2'b00};
        end
        S_MEMADR, S_ADDIEX: r_alu_out <= r_a + w_imm_sext;
        S_MEMRD:  if (w_mem_fire) r_mdr <= mem_rdata;
        S_RTEX:   r_alu_out <= w_alu_result;
        S_BRANCH: if (r_a == r_b) r_pc <= r_alu_out;
        S_JUMP:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rt;
    w_rf_wdata = r_alu_out;
    case (r_state)
      S_MEMWB: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = r_mdr;
      end
      S_RTWB: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = w_rd;
      end
      S_ADDIWB: w_rf_we = 1'b1;
      default: ;
    endcase
  end

  // Register file contents survive reset; register 0 is never written.
  always_ff @(posedge clk) begin
    if (reset && w_rf_we && (w_rf_waddr != '0)) begin
      r_regs[w_rf_waddr] <= w_rf_wdata;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
`timescale 1ns/1ps
module tb_mc_datapath;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMRD = 4'd3;
  localparam logic [3:0] ST_JUMP  = 4'd11, ST_TRAP = 4'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [3:0]  state;

  logic        hi_req, hi_we, hi_retire, hi_trap;
  logic [31:0] hi_addr, hi_wdata, hi_pc;
  logic [3:0]  hi_state;

  logic [31:0] mem [1024];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  mc_datapath #(.RESET_PC(32'h0000_0100), .NUM_REGS(32)) u_dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .state(state), .retire(retire), .trap(trap)
  );

  // Second instance in the 0x1000_0000 region: memory always returns j 0x40.
  mc_datapath #(.RESET_PC(32'h1000_0000), .NUM_REGS(32)) u_dut_hi (
    .clk(clk), .reset(reset),
    .mem_req(hi_req), .mem_we(hi_we), .mem_addr(hi_addr),
    .mem_wdata(hi_wdata), .mem_rdata(32'h0800_0040), .mem_ready(1'b1),
    .pc(hi_pc), .state(hi_state), .retire(hi_retire), .trap(hi_trap)
  );

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) mem[mem_addr[11:2]] <= mem_wdata;
  end

  task automatic run_to_retire(input int start_n, output int n);
    n = start_n;
    while (retire !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (pc !== 32'h100) $display("FAIL reset_pc: got %h expected %h", pc, 32'h100); else n_pass++;
    n_checks++; if (state !== ST_FETCH) $display("FAIL reset_state: got %0d expected %0d", state, ST_FETCH); else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", mem_req); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", mem_we); else n_pass++;
    n_checks++; if (retire !== 1'b0) $display("FAIL reset_retire: got %b expected 0", retire); else n_pass++;
    n_checks++; if (trap !== 1'b0) $display("FAIL reset_trap: got %b expected 0", trap); else n_pass++;
    n_checks++; if (hi_wdata !== 32'h0) $display("FAIL reset_b_cleared: got %h expected 0", hi_wdata); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) $display("FAIL fetch_req: got %b expected 1", mem_req); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL fetch_we: got %b expected 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 32'h100) $display("FAIL fetch_addr: got %h expected %h", mem_addr, 32'h100); else n_pass++;
    n_checks++; if (hi_addr !== 32'h1000_0000) $display("FAIL hi_fetch_addr: got %h expected %h", hi_addr, 32'h1000_0000); else n_pass++;
    @(negedge clk);
    n_checks++; if (state !== ST_DECODE) $display("FAIL decode_state: got %0d expected %0d", state, ST_DECODE); else n_pass++;
    n_checks++; if (pc !== 32'h104) $display("FAIL decode_pc: got %h expected %h", pc, 32'h104); else n_pass++;
    n_checks++; if (hi_pc !== 32'h1000_0004) $display("FAIL hi_decode_pc: got %h expected %h", hi_pc, 32'h1000_0004); else n_pass++;
  endtask

  // Runs in lock-step with the first addi of the main instance (cycles 3-4).
  task automatic test_jump_upper();
    @(negedge clk);
    n_checks++; if (hi_state !== ST_JUMP) $display("FAIL hi_jump_state: got %0d expected %0d", hi_state, ST_JUMP); else n_pass++;
    n_checks++; if (hi_retire !== 1'b1 || hi_req !== 1'b0) $display("FAIL hi_jump_retire: got %b/%b expected 1/0", hi_retire, hi_req); else n_pass++;
    @(negedge clk);
    n_checks++; if (hi_pc !== 32'h1000_0100) $display("FAIL hi_jump_pc: got %h expected %h", hi_pc, 32'h1000_0100); else n_pass++;
    n_checks++; if (hi_we !== 1'b0 || hi_trap !== 1'b0) $display("FAIL hi_idle_flags: got %b/%b expected 0/0", hi_we, hi_trap); else n_pass++;
  endtask

  task automatic test_alu_program();
    int n;
    run_to_retire(4, n);
    n_checks++; if (n !== 4) $display("FAIL addi1_latency: got %0d expected 4", n); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      run_to_retire(1, n);
      n_checks++; if (n !== 4) $display("FAIL seq_latency[%0d]: got %0d expected 4", i, n); else n_pass++;
    end
    @(negedge clk);
    run_to_retire(1, n);
    n_checks++; if (n !== 4) $display("FAIL sw_latency: got %0d expected 4", n); else n_pass++;
    n_checks++; if (mem_we !== 1'b1) $display("FAIL sw_we: got %b expected 1", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 32'h8) $display("FAIL sw_addr: got %h expected %h", mem_addr, 32'h8); else n_pass++;
    n_checks++; if (mem_wdata !== 32'd12) $display("FAIL sw_wdata: got %h expected %h", mem_wdata, 32'd12); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_lw_stall();
    int n;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) $display("FAIL lw_req: got %b/%b expected 1/0", mem_req, mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 32'h8) $display("FAIL lw_addr: got %h expected %h", mem_addr, 32'h8); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (state !== ST_MEMRD) $display("FAIL lw_stall_state[%0d]: got %0d expected %0d", k, state, ST_MEMRD); else n_pass++;
      n_checks++; if (mem_addr !== 32'h8) $display("FAIL lw_stall_addr[%0d]: got %h expected %h", k, mem_addr, 32'h8); else n_pass++;
    end
    mem_ready = 1'b1;
    run_to_retire(7, n);
    n_checks++; if (n !== 8) $display("FAIL lw_latency: got %0d expected 8", n); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_r0();
    int n;
    run_to_retire(1, n);
    n_checks++; if (n !== 4) $display("FAIL add_r0_latency: got %0d expected 4", n); else n_pass++;
    @(negedge clk);
    run_to_retire(1, n);
    n_checks++; if (mem_addr !== 32'hC || mem_wdata !== 32'h0) $display("FAIL r0_reads_zero: got %h@%h expected 0@c", mem_wdata, mem_addr); else n_pass++;
    @(negedge clk);
    run_to_retire(1, n);
    n_checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'd12) $display("FAIL lw_result_r4: got %h@%h expected c@10", mem_wdata, mem_addr); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_alu_ops();
    int n;
    logic [31:0] exp_val [6];
    exp_val = '{32'hFFFF_FFFE, 32'h1, 32'h0, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    for (int i = 0; i < 6; i++) begin
      run_to_retire(1, n);
      n_checks++; if (n !== 4) $display("FAIL alu_latency[%0d]: got %0d expected 4", i, n); else n_pass++;
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      run_to_retire(1, n);
      n_checks++;
      if (mem_addr !== 32'h200 + 32'(4 * i) || mem_wdata !== exp_val[i])
        $display("FAIL alu_result[%0d]: got %h@%h expected %h@%h", i, mem_wdata, mem_addr, exp_val[i], 32'h200 + 32'(4 * i));
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_branch_jump();
    int n;
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h20, 32'h1C, 32'h40, 32'h44};
    for (int i = 0; i < 4; i++) begin
      run_to_retire(1, n);
      n_checks++; if (n !== 3) $display("FAIL ctl_latency[%0d]: got %0d expected 3", i, n); else n_pass++;
      @(negedge clk);
      n_checks++; if (pc !== exp_pc[i]) $display("FAIL ctl_pc[%0d]: got %h expected %h", i, pc, exp_pc[i]); else n_pass++;
    end
  endtask

  task automatic test_invalid();
`ifdef MC_INVALID_TRAP_EN
    @(negedge clk);
    n_checks++; if (retire !== 1'b0) $display("FAIL trap_decode_retire: got %b expected 0", retire); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (trap !== 1'b1 || mem_req !== 1'b0 || retire !== 1'b0 || state !== ST_TRAP || pc !== 32'h48)
        $display("FAIL trap_hold[%0d]: got trap=%b req=%b ret=%b st=%0d pc=%h expected 1 0 0 12 48", k, trap, mem_req, retire, state, pc);
      else n_pass++;
    end
`else
    int n;
    run_to_retire(1, n);
    n_checks++; if (n !== 2) $display("FAIL nop_opcode_latency: got %0d expected 2", n); else n_pass++;
    @(negedge clk);
    n_checks++; if (pc !== 32'h48 || state !== ST_FETCH || trap !== 1'b0) $display("FAIL nop_opcode_next: got pc=%h st=%0d trap=%b expected 48 0 0", pc, state, trap); else n_pass++;
    run_to_retire(1, n);
    n_checks++; if (n !== 3) $display("FAIL nop_funct_latency: got %0d expected 3", n); else n_pass++;
    @(negedge clk);
    n_checks++; if (pc !== 32'h4C) $display("FAIL nop_funct_pc: got %h expected %h", pc, 32'h4C); else n_pass++;
    run_to_retire(1, n);
    n_checks++; if (mem_addr !== 32'h218 || mem_wdata !== 32'd5) $display("FAIL after_nop_sw: got %h@%h expected 5@218", mem_wdata, mem_addr); else n_pass++;
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid_access();
    mem_ready = 1'b0;
`ifndef MC_INVALID_TRAP_EN
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h50) $display("FAIL pre_reset_fetch: got %b@%h expected 1@50", mem_req, mem_addr); else n_pass++;
`endif
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) $display("FAIL midreset_req: got %b expected 0", mem_req); else n_pass++;
    n_checks++; if (pc !== 32'h100 || state !== ST_FETCH || trap !== 1'b0) $display("FAIL midreset_regs: got pc=%h st=%0d trap=%b expected 100 0 0", pc, state, trap); else n_pass++;
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) $display("FAIL refetch: got %b@%h expected 1@100", mem_req, mem_addr); else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] <= '0;
    mem['h100/4] <= 32'h2001_0005;  // addi $1,$0,5
    mem['h104/4] <= 32'h2002_0007;  // addi $2,$0,7
    mem['h108/4] <= 32'h0022_1820;  // add  $3,$1,$2
    mem['h10C/4] <= 32'hAC03_0008;  // sw   $3,8($0)
    mem['h110/4] <= 32'h8C04_0008;  // lw   $4,8($0)
    mem['h114/4] <= 32'h0022_0020;  // add  $0,$1,$2
    mem['h118/4] <= 32'hAC00_000C;  // sw   $0,12($0)
    mem['h11C/4] <= 32'hAC04_0010;  // sw   $4,16($0)
    mem['h120/4] <= 32'h0022_2822;  // sub  $5,$1,$2
    mem['h124/4] <= 32'h00A1_302A;  // slt  $6,$5,$1
    mem['h128/4] <= 32'h0025_382A;  // slt  $7,$1,$5
    mem['h12C/4] <= 32'h0022_4024;  // and  $8,$1,$2
    mem['h130/4] <= 32'h00A2_4825;  // or   $9,$5,$2
    mem['h134/4] <= 32'h20AA_FFFD;  // addi $10,$5,-3
    mem['h138/4] <= 32'hAC05_0200;  // sw   $5,0x200($0)
    mem['h13C/4] <= 32'hAC06_0204;
    mem['h140/4] <= 32'hAC07_0208;
    mem['h144/4] <= 32'hAC08_020C;
    mem['h148/4] <= 32'hAC09_0210;
    mem['h14C/4] <= 32'hAC0A_0214;
    mem['h150/4] <= 32'h0800_0008;  // j    0x8   -> 0x20
    mem['h20/4]  <= 32'h1021_FFFE;  // beq  $1,$1,-2 -> 0x1C
    mem['h1C/4]  <= 32'h0800_0010;  // j    0x10  -> 0x40
    mem['h40/4]  <= 32'h1022_0005;  // beq  $1,$2,5 (not taken)
    mem['h44/4]  <= 32'hFC00_0000;  // invalid opcode
    mem['h48/4]  <= 32'h0022_5821;  // invalid funct
    mem['h4C/4]  <= 32'hAC01_0218;  // sw   $1,0x218($0)

    test_reset();
    test_jump_upper();
    test_alu_program();
    test_lw_stall();
    test_r0();
    test_alu_ops();
    test_branch_jump();
    test_invalid();
    test_reset_mid_access();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
